new_pe_conv_gen: RTL and testbench

NEW_PE_CONV_GEN -- requirements
Module: new_pe_conv_gen

---
 rtl/new_pe_conv_gen.sv | 167 ++++++++++++++++
 tb/tb_new_pe_conv_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/new_pe_conv_gen.sv
// -----------------------------------------------------------------------------
// new_pe_conv_gen
//   One processing element of a 1-D convolution chain. Holds a K-tap sliding
//   window of ifmap samples and a K-tap weight register, multiplies tap-wise,
//   and adds the products to the partial sum arriving from the previous PE.
//   Pipeline: accept (stage 0) -> products (stage 1) -> accumulate (stage 2),
//   so a result appears two enabled edges after the sample that completes
//   the window.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           global enable; 0 freezes every register
//   clr          synchronous clear of window, fill count, valids, sticky flag
//   wt_load      load weight register from filtr_in
//   filtr_in     K*WW weights, tap i at [i*WW +: WW]
//   filtr_out    registered weights, daisy-chained to the next PE
//   ifmap_in     DW-bit sample, qualified by ifmap_vld
//   ifmap_out    tap 0 (newest sample), shift chain to the next PE
//   psum_in      signed partial sum from the previous PE
//   psum_out     signed result, qualified by psum_vld (held otherwise)
//   sat_sticky   a clamp has happened since reset/clr (SAT=1 only)
// -----------------------------------------------------------------------------
module new_pe_conv_gen #(
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int PSW    = 20,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            wt_load,
  input  logic [K*WW-1:0] filtr_in,
  output logic [K*WW-1:0] filtr_out,
  input  logic [DW-1:0]   ifmap_in,
  input  logic            ifmap_vld,
  output logic [DW-1:0]   ifmap_out,
  input  logic [PSW-1:0]  psum_in,
  output logic [PSW-1:0]  psum_out,
  output logic            psum_vld,
  output logic            sat_sticky
);

  localparam int PW = DW + WW;             // full product width
  localparam int CW = $clog2(K + 1);       // fill counter width
  localparam int SW = PSW + CW + 1;        // accumulation width, cannot overflow

  localparam logic signed [SW-1:0] MAXV = {{(SW-PSW+1){1'b0}}, {(PSW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-PSW+1){1'b1}}, {(PSW-1){1'b0}}};

  logic [DW-1:0]   r_tap [K];
  logic [CW-1:0]   r_cnt;
  logic [K*WW-1:0] r_wt;
  logic [PSW-1:0]  r_s0_psum;
  logic            r_s0_vld;
  logic [PW-1:0]   r_prod [K];
  logic [PSW-1:0]  r_s1_psum;
  logic            r_s1_vld;
  logic [PSW-1:0]  r_psum_out;
  logic            r_psum_vld;
  logic            r_sat;

  logic [CW-1:0]        w_cnt_nxt;
  logic [PW-1:0]        w_prod [K];
  logic signed [SW-1:0] w_sum;
  logic                 w_over;
  logic                 w_under;
  logic                 w_clamp;
  logic [PSW-1:0]       w_res;

  // Fill counter saturates at K; once full every accept yields a valid window.
  assign w_cnt_nxt = (r_cnt == CW'(K)) ? r_cnt : r_cnt + 1'b1;

  // Products use the taps and weights as registered before the stage-1 edge.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      if (SIGNED != 0) w_prod[i] = $signed(r_tap[i]) * $signed(r_wt[i*WW +: WW]);
      else             w_prod[i] = r_tap[i] * r_wt[i*WW +: WW];
    end
  end

  // Stage-2 accumulate at a width wide enough to never wrap, then clamp or
  // truncate. psum_in is always signed; products follow SIGNED.
  always_comb begin
    // NOTE: every combinational output is assigned before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_sum   = SW'($signed(r_s1_psum));
    w_res   = '0;
    w_clamp = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (SIGNED != 0) w_sum = w_sum + SW'($signed(r_prod[i]));
      else             w_sum = w_sum + SW'(r_prod[i]);
    end
    w_over  = (w_sum > MAXV);
    w_under = (w_sum < MINV);
    if (SAT != 0 && w_over) begin
      w_res   = MAXV[PSW-1:0];
      w_clamp = 1'b1;
    end else if (SAT != 0 && w_under) begin
      w_res   = MINV[PSW-1:0];
      w_clamp = 1'b1;
    end else begin
      w_res   = w_sum[PSW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tap window and product array are register arrays, not RAM,
      // and must come out of reset empty, so they are reset element by element.
      for (int i = 0; i < K; i++) begin
        r_tap[i]  <= '0;
        r_prod[i] <= '0;
      end
      r_cnt      <= '0;
      r_wt       <= '0;
      r_s0_psum  <= '0;
      r_s0_vld   <= 1'b0;
      r_s1_psum  <= '0;
      r_s1_vld   <= 1'b0;
      r_psum_out <= '0;
      r_psum_vld <= 1'b0;
      r_sat      <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every stage samples the values
      // its predecessor held before this edge, independent of statement order.
      if (wt_load) r_wt <= filtr_in;
      for (int i = 0; i < K; i++) r_prod[i] <= w_prod[i];
      r_s1_psum <= r_s0_psum;
      if (clr) begin
        // Clear wins over a same-edge accept; psum_out and weights survive.
        for (int i = 0; i < K; i++) r_tap[i] <= '0;
        r_cnt      <= '0;
        r_s0_vld   <= 1'b0;
        r_s1_vld   <= 1'b0;
        r_psum_vld <= 1'b0;
        r_sat      <= 1'b0;
      end else begin
        r_s1_vld   <= r_s0_vld;
        r_psum_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_psum_out <= w_res;
          if (w_clamp) r_sat <= 1'b1;
        end
        if (ifmap_vld) begin
          r_tap[0] <= ifmap_in;
          for (int i = 1; i < K; i++) r_tap[i] <= r_tap[i-1];
          r_cnt     <= w_cnt_nxt;
          r_s0_psum <= psum_in;
          r_s0_vld  <= (w_cnt_nxt == CW'(K));
        end else begin
          r_s0_vld  <= 1'b0;   // bubble
        end
      end
    end
  end

  assign filtr_out  = r_wt;
  assign ifmap_out  = r_tap[0];
  assign psum_out   = r_psum_out;
  assign psum_vld   = r_psum_vld;
  assign sat_sticky = r_sat;

endmodule

// File: tb/tb_new_pe_conv_gen.sv
// -----------------------------------------------------------------------------
// tb_new_pe_conv_gen
//   Three instances share one stimulus: signed+saturating (ss), unsigned+
//   saturating (us) and signed+wrapping (sw). A transaction-level model keeps
//   the sample window as a queue and schedules each completed window as a
//   pending result, evaluated with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_new_pe_conv_gen;
  localparam int K = 3, DW = 8, WW = 8, PSW = 20;

  logic          clk = 1'b0;
  logic          rst_n, en, clr, wt_load, ifmap_vld;
  logic [23:0]   filtr_in;
  logic [7:0]    ifmap_in;
  logic [19:0]   psum_in;

  logic [23:0]   fo_ss, fo_us, fo_sw;
  logic [7:0]    io_ss, io_us, io_sw;
  logic [19:0]   po_ss, po_us, po_sw;
  logic          pv_ss, pv_us, pv_sw;
  logic          st_ss, st_us, st_sw;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  new_pe_conv_gen #(.K(K), .DW(DW), .WW(WW), .PSW(PSW), .SIGNED(1), .SAT(1)) u_ss (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wt_load(wt_load),
    .filtr_in(filtr_in), .filtr_out(fo_ss), .ifmap_in(ifmap_in), .ifmap_vld(ifmap_vld),
    .ifmap_out(io_ss), .psum_in(psum_in), .psum_out(po_ss), .psum_vld(pv_ss), .sat_sticky(st_ss));
  new_pe_conv_gen #(.K(K), .DW(DW), .WW(WW), .PSW(PSW), .SIGNED(0), .SAT(1)) u_us (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wt_load(wt_load),
    .filtr_in(filtr_in), .filtr_out(fo_us), .ifmap_in(ifmap_in), .ifmap_vld(ifmap_vld),
    .ifmap_out(io_us), .psum_in(psum_in), .psum_out(po_us), .psum_vld(pv_us), .sat_sticky(st_us));
  new_pe_conv_gen #(.K(K), .DW(DW), .WW(WW), .PSW(PSW), .SIGNED(1), .SAT(0)) u_sw (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wt_load(wt_load),
    .filtr_in(filtr_in), .filtr_out(fo_sw), .ifmap_in(ifmap_in), .ifmap_vld(ifmap_vld),
    .ifmap_out(io_sw), .psum_in(psum_in), .psum_out(po_sw), .psum_vld(pv_sw), .sat_sticky(st_sw));

  // ---------------- reference model ----------------
  typedef struct {
    logic [23:0] smp;        // window snapshot, newest sample in [7:0]
    logic [19:0] pin;
    int          prod_tick;
    int          out_tick;
    longint      sum_s;
    longint      sum_u;
  } item_t;

  logic [7:0]  win[$];       // accepted samples, newest at index 0
  item_t       pend[$];
  logic [7:0]  m_w [3];
  int          tick;
  logic [19:0] e_ss, e_us, e_sw;
  bit          e_vld, e_sat_ss, e_sat_us;

  function automatic logic [19:0] sat20(input longint v, output bit hit);
    hit = 1'b0;
    if (v > 64'sd524287)  begin hit = 1'b1; return 20'h7FFFF; end
    if (v < -64'sd524288) begin hit = 1'b1; return 20'h80000; end
    return 20'(v);
  endfunction

  task automatic model_reset();
    win.delete(); pend.delete();
    for (int i = 0; i < 3; i++) m_w[i] = '0;
    tick = 0; e_ss = '0; e_us = '0; e_sw = '0;
    e_vld = 0; e_sat_ss = 0; e_sat_us = 0;
  endtask

  // Called right after a rising edge, while the inputs of that edge are stable.
  task automatic model_edge();
    bit          h;
    logic [7:0]  a, b;
    item_t       it;
    if (!rst_n || !en) return;
    tick++;
    if (clr) begin
      win.delete(); pend.delete();
      e_vld = 0; e_sat_ss = 0; e_sat_us = 0;
    end else begin
      e_vld = 0;
      if (pend.size() > 0 && pend[0].out_tick == tick) begin
        it = pend[0];
        void'(pend.pop_front());
        e_vld = 1;
        e_ss = sat20(it.sum_s, h); if (h) e_sat_ss = 1;
        e_us = sat20(it.sum_u, h); if (h) e_sat_us = 1;
        e_sw = 20'(it.sum_s);
      end
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].prod_tick == tick) begin
          pend[j].sum_s = longint'($signed(pend[j].pin));
          pend[j].sum_u = longint'($signed(pend[j].pin));
          for (int i = 0; i < 3; i++) begin
            a = pend[j].smp[i*8 +: 8];
            b = m_w[i];
            pend[j].sum_s += longint'($signed(a)) * longint'($signed(b));
            pend[j].sum_u += longint'(a) * longint'(b);
          end
        end
      end
      if (ifmap_vld) begin
        win.push_front(ifmap_in);
        if (win.size() > 3) void'(win.pop_back());
        if (win.size() == 3) begin
          it.smp = {win[2], win[1], win[0]};
          it.pin = psum_in;
          it.prod_tick = tick + 1;
          it.out_tick  = tick + 2;
          it.sum_s = 0; it.sum_u = 0;
          pend.push_back(it);
        end
      end
    end
    if (wt_load) for (int i = 0; i < 3; i++) m_w[i] = filtr_in[i*8 +: 8];
  endtask

  // Apply one set of inputs for one rising edge; return 1 time unit after it.
  task automatic drive(input bit e, input bit c, input bit v, input bit wl,
                       input logic [7:0] d, input logic [19:0] p, input logic [23:0] f);
    en = e; clr = c; ifmap_vld = v; wt_load = wl; ifmap_in = d; psum_in = p; filtr_in = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_cmp++; if ({po_ss, pv_ss, st_ss} !== 21'd0) begin n_err++;
      $display("FAIL reset_psum: got out=%0d vld=%b sat=%b want 0/0/0", po_ss, pv_ss, st_ss); end
    n_cmp++; if ({fo_ss, io_ss} !== 32'd0) begin n_err++;
      $display("FAIL reset_chain: got filtr=%h ifmap=%h want 0/0", fo_ss, io_ss); end
  endtask

  task automatic test_basic();
    drive(1, 1, 0, 0, 0, 0, 24'h0);
    drive(1, 0, 0, 1, 0, 0, {8'd3, 8'd2, 8'd1});
    n_cmp++; if (fo_ss !== 24'h030201) begin n_err++;
      $display("FAIL basic_filtr_out: got %h want 030201", fo_ss); end
    drive(1, 0, 1, 0, 8'd10, 20'd5, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL basic_vld_s1: got %b want 0", pv_ss); end
    drive(1, 0, 1, 0, 8'd20, 20'd5, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL basic_vld_s2: got %b want 0", pv_ss); end
    drive(1, 0, 1, 0, 8'd30, 20'd5, 24'h0);
    n_cmp++; if (io_ss !== 8'd30) begin n_err++; $display("FAIL basic_ifmap_out: got %0d want 30", io_ss); end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL basic_vld_early: got %b want 0", pv_ss); end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b1 || po_ss !== 20'd105) begin n_err++;
      $display("FAIL basic_result: got vld=%b out=%0d want 1/105", pv_ss, po_ss); end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0 || po_ss !== 20'd105) begin n_err++;
      $display("FAIL basic_hold: got vld=%b out=%0d want 0/105", pv_ss, po_ss); end
  endtask

  task automatic test_signedness();
    drive(1, 1, 0, 1, 0, 0, 24'hFFFFFF);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 8'h80, 20'd0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b1 || po_ss !== 20'd384) begin n_err++;
      $display("FAIL signed_neg: got vld=%b out=%0d want 1/384", pv_ss, po_ss); end
    n_cmp++; if (pv_us !== 1'b1 || po_us !== 20'd97920) begin n_err++;
      $display("FAIL unsigned_big: got vld=%b out=%0d want 1/97920", pv_us, po_us); end
  endtask

  task automatic test_saturate();
    logic [19:0] wrap_exp;
    wrap_exp = 20'(-476189);
    drive(1, 1, 0, 1, 0, 0, 24'h7F7F7F);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 8'd127, 20'd524000, 24'h0);
    n_cmp++; if (st_ss !== 1'b0) begin n_err++; $display("FAIL sat_early: got %b want 0", st_ss); end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (po_ss !== 20'd524287 || st_ss !== 1'b1) begin n_err++;
      $display("FAIL sat_clamp: got out=%0d sat=%b want 524287/1", po_ss, st_ss); end
    n_cmp++; if (po_sw !== wrap_exp || st_sw !== 1'b0) begin n_err++;
      $display("FAIL sat_wrap: got out=%h sat=%b want %h/0", po_sw, st_sw, wrap_exp); end
    n_cmp++; if (po_us !== 20'd524287 || st_us !== 1'b1) begin n_err++;
      $display("FAIL sat_unsigned: got out=%0d sat=%b want 524287/1", po_us, st_us); end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 1, 0, 0, {8'd3, 8'd2, 8'd1});
    n_cmp++; if (st_ss !== 1'b0 || po_ss !== 20'd524287) begin n_err++;
      $display("FAIL clr_keep_psum: got sat=%b out=%0d want 0/524287", st_ss, po_ss); end
    drive(1, 0, 1, 0, 8'd10, 20'd5, 24'h0);
    drive(1, 0, 1, 0, 8'd20, 20'd5, 24'h0);
    drive(1, 0, 1, 0, 8'd30, 20'd5, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);                  // product stage
    for (int i = 0; i < 4; i++) begin
      drive(0, i == 1, 1, 1, 8'(i * 7 + 1), 20'd999, 24'h111111);
      n_cmp++; if (pv_ss !== 1'b0 || po_ss !== 20'd524287 || fo_ss !== 24'h030201 || io_ss !== 8'd30) begin
        n_err++; $display("FAIL stall_hold%0d: got vld=%b out=%0d filtr=%h ifmap=%0d want 0/524287/030201/30",
                          i, pv_ss, po_ss, fo_ss, io_ss); end
    end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b1 || po_ss !== 20'd105) begin n_err++;
      $display("FAIL stall_resume: got vld=%b out=%0d want 1/105", pv_ss, po_ss); end
  endtask

  task automatic test_clr();
    drive(1, 0, 1, 0, 8'd50, 20'd0, 24'h0);
    drive(1, 0, 1, 0, 8'd60, 20'd0, 24'h0);
    drive(1, 1, 1, 0, 8'd70, 20'd0, 24'h0);          // clr beats accept
    n_cmp++; if (io_ss !== 8'd0) begin n_err++; $display("FAIL clr_taps: got %0d want 0", io_ss); end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 0, 8'(i), 20'd0, 24'h0);
      n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL clr_novld%0d: got %b want 0", i, pv_ss); end
    end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL clr_novld_lat: got %b want 0", pv_ss); end
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b1 || po_ss !== 20'd10) begin n_err++;
      $display("FAIL clr_result: got vld=%b out=%0d want 1/10", pv_ss, po_ss); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 1, 1, 8'd9, 20'd3, 24'h050505);
    drive(1, 0, 1, 0, 8'd9, 20'd3, 24'h0);
    drive(1, 0, 1, 0, 8'd9, 20'd3, 24'h0);
    drive(1, 0, 1, 0, 8'd9, 20'd3, 24'h0);
    drive(1, 0, 1, 0, 8'd9, 20'd3, 24'h0);           // pipeline full of valid data
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if ({po_ss, pv_ss, st_ss, fo_ss, io_ss} !== 53'd0) begin n_err++;
      $display("FAIL async_rst: got out=%0d vld=%b sat=%b filtr=%h ifmap=%h want all 0",
               po_ss, pv_ss, st_ss, fo_ss, io_ss); end
    n_cmp++; if ({po_us, po_sw, pv_us, pv_sw} !== 42'd0) begin n_err++;
      $display("FAIL async_rst_var: got us=%0d sw=%0d want 0/0", po_us, po_sw); end
    #2 rst_n = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 24'h010101);
    drive(1, 0, 1, 0, 8'd4, 20'd0, 24'h0);
    drive(1, 0, 1, 0, 8'd5, 20'd0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b0) begin n_err++; $display("FAIL rst_refill: got %b want 0", pv_ss); end
    drive(1, 0, 1, 0, 8'd6, 20'd0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    drive(1, 0, 0, 0, 0, 0, 24'h0);
    n_cmp++; if (pv_ss !== 1'b1 || po_ss !== 20'd15) begin n_err++;
      $display("FAIL rst_refill_result: got vld=%b out=%0d want 1/15", pv_ss, po_ss); end
  endtask

  task automatic test_random();
    logic [23:0] exp_f;
    logic [7:0]  exp_i;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0, 8'($urandom), 20'($urandom), 24'($urandom));
      exp_f = {m_w[2], m_w[1], m_w[0]};
      exp_i = (win.size() > 0) ? win[0] : 8'd0;
      n_cmp++; if ({pv_ss, pv_us, pv_sw} !== {3{e_vld}}) begin n_err++;
        $display("FAIL rnd_vld@%0d: got %b%b%b want %b", n, pv_ss, pv_us, pv_sw, e_vld); end
      n_cmp++; if (po_ss !== e_ss || st_ss !== e_sat_ss) begin n_err++;
        $display("FAIL rnd_ss@%0d: got %h/%b want %h/%b", n, po_ss, st_ss, e_ss, e_sat_ss); end
      n_cmp++; if (po_us !== e_us || st_us !== e_sat_us) begin n_err++;
        $display("FAIL rnd_us@%0d: got %h/%b want %h/%b", n, po_us, st_us, e_us, e_sat_us); end
      n_cmp++; if (po_sw !== e_sw || st_sw !== 1'b0) begin n_err++;
        $display("FAIL rnd_sw@%0d: got %h/%b want %h/0", n, po_sw, st_sw, e_sw); end
      n_cmp++; if (fo_ss !== exp_f || io_ss !== exp_i) begin n_err++;
        $display("FAIL rnd_chain@%0d: got %h/%h want %h/%h", n, fo_ss, io_ss, exp_f, exp_i); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; wt_load = 1'b0; ifmap_vld = 1'b0;
    filtr_in = '0; ifmap_in = '0; psum_in = '0;
    model_reset();
    #12;
    test_reset();
    #1 rst_n = 1'b1;
    test_basic();
    test_signedness();
    test_saturate();
    test_stall();
    test_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
